reorder_buffer: RTL and testbench

Circular reorder buffer between the decoder/dispatch stage and the architectural register file. It allocates a ROB id per issued instruction and captures results broadcast by the reservation-station/ALU path and the LSB. It retires instructions in order, one per cycle, and raises a pipeline flush when a mispredicted branch retires. It also answers the decoder's operand lookups for in-flight results, including same-cycle bypass.

---
 rtl/reorder_buffer.sv | 160 ++++++++++++++++
 tb/tb_reorder_buffer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: hands out ids at issue, captures ALU/LSB results,
// retires in order one per cycle and raises a flush on a retired mispredict.
module reorder_buffer #(
  parameter int ROB_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                issue_valid,
  input  logic [1:0]          issue_type,
  input  logic [4:0]          issue_rd,
  input  logic [31:0]         issue_value,
  input  logic [31:0]         issue_pc,
  input  logic [31:0]         issue_target,
  input  logic                issue_pred_taken,
  output logic [ROB_BITS-1:0] rob_tail_id,
  output logic [ROB_BITS-1:0] rob_head_id,
  output logic                rob_full,
  input  logic                alu_ready,
  input  logic [ROB_BITS-1:0] alu_rob_id,
  input  logic [31:0]         alu_value,
  input  logic                lsb_ready,
  input  logic [ROB_BITS-1:0] lsb_rob_id,
  input  logic [31:0]         lsb_value,
  input  logic [ROB_BITS-1:0] q1_id,
  input  logic [ROB_BITS-1:0] q2_id,
  output logic                q1_ready,
  output logic                q2_ready,
  output logic [31:0]         q1_value,
  output logic [31:0]         q2_value,
  output logic                commit_reg_valid,
  output logic [4:0]          commit_rd,
  output logic [31:0]         commit_value,
  output logic [ROB_BITS-1:0] commit_rob_id,
  output logic                commit_store,
  output logic                flush,
  output logic [31:0]         flush_pc
);
  localparam int DEPTH = 1 << ROB_BITS;
  localparam logic [ROB_BITS:0] FULL_CNT = {1'b1, {ROB_BITS{1'b0}}};
  localparam logic [1:0] T_REG = 2'd0, T_STORE = 2'd1, T_BRANCH = 2'd2, T_REG_DONE = 2'd3;

  logic [DEPTH-1:0] busy, done, e_pred;
  logic [1:0]       e_type   [DEPTH];
  logic [4:0]       e_rd     [DEPTH];
  logic [31:0]      e_value  [DEPTH];
  logic [31:0]      e_pc     [DEPTH];
  logic [31:0]      e_target [DEPTH];

  logic [ROB_BITS-1:0] head, tail;
  logic [ROB_BITS:0]   count, count_next;
  logic issue_ok, alu_ok, lsb_ok, retire, head_taken, head_is_reg, mispredict;

  assign rob_head_id = head;
  assign rob_tail_id = tail;

  // Everything is frozen while the flush pulse is out; the buffer is empty then.
  assign issue_ok    = rdy && issue_valid && !flush && !rob_full;
  assign alu_ok      = rdy && alu_ready && !flush && busy[alu_rob_id];
  assign lsb_ok      = rdy && lsb_ready && !flush && busy[lsb_rob_id];
  assign retire      = rdy && !flush && busy[head] && done[head];
  assign head_taken  = e_value[head][0];
  assign head_is_reg = (e_type[head] == T_REG) || (e_type[head] == T_REG_DONE);
  assign mispredict  = retire && (e_type[head] == T_BRANCH) && (head_taken != e_pred[head]);

  always_comb begin
    count_next = count;
    if (issue_ok && !retire)      count_next = count + (ROB_BITS+1)'(1);
    else if (!issue_ok && retire) count_next = count - (ROB_BITS+1)'(1);
  end

  // Operand lookup: stored result first, then same-cycle bypass, ALU before LSB.
  logic [1:0][ROB_BITS-1:0] q_id;
  logic [1:0]               q_rdy;
  logic [1:0][31:0]         q_val;
  assign q_id = {q2_id, q1_id};

  always_comb begin
    q_rdy = '0;
    q_val = '0;
    for (int i = 0; i < 2; i++) begin
      if (done[q_id[i]]) begin
        q_rdy[i] = 1'b1; q_val[i] = e_value[q_id[i]];
      end else if (alu_ready && alu_rob_id == q_id[i]) begin
        q_rdy[i] = 1'b1; q_val[i] = alu_value;
      end else if (lsb_ready && lsb_rob_id == q_id[i]) begin
        q_rdy[i] = 1'b1; q_val[i] = lsb_value;
      end
    end
  end

  assign q1_ready = q_rdy[0];
  assign q2_ready = q_rdy[1];
  assign q1_value = q_val[0];
  assign q2_value = q_val[1];

  // Payload storage; validity is tracked by busy/done, so no reset needed.
  always_ff @(posedge clk) begin
    if (issue_ok) begin
      e_type[tail]   <= issue_type;
      e_rd[tail]     <= issue_rd;
      e_value[tail]  <= issue_value;
      e_pc[tail]     <= issue_pc;
      e_target[tail] <= issue_target;
      e_pred[tail]   <= issue_pred_taken;
    end
    if (lsb_ok) e_value[lsb_rob_id] <= lsb_value;
    if (alu_ok) e_value[alu_rob_id] <= alu_value;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy             <= '0;
      done             <= '0;
      head             <= '0;
      tail             <= '0;
      count            <= '0;
      rob_full         <= 1'b0;
      commit_reg_valid <= 1'b0;
      commit_rd        <= '0;
      commit_value     <= '0;
      commit_rob_id    <= '0;
      commit_store     <= 1'b0;
      flush            <= 1'b0;
      flush_pc         <= '0;
    end else if (rdy) begin
      commit_reg_valid <= retire && head_is_reg;
      commit_store     <= retire && (e_type[head] == T_STORE);
      flush            <= mispredict;
      if (retire && head_is_reg) begin
        commit_rd     <= e_rd[head];
        commit_value  <= e_value[head];
        commit_rob_id <= head;
      end
      if (mispredict) begin
        flush_pc <= head_taken ? e_target[head] : e_pc[head] + 32'd4;
        busy     <= '0;
        done     <= '0;
        head     <= '0;
        tail     <= '0;
        count    <= '0;
        rob_full <= 1'b0;
      end else begin
        if (issue_ok) begin
          busy[tail] <= 1'b1;
          done[tail] <= (issue_type == T_REG_DONE);
          tail       <= tail + ROB_BITS'(1);
        end
        if (lsb_ok) done[lsb_rob_id] <= 1'b1;
        if (alu_ok) done[alu_rob_id] <= 1'b1;
        if (retire) begin
          busy[head] <= 1'b0;
          head       <= head + ROB_BITS'(1);
        end
        count    <= count_next;
        rob_full <= (count_next == FULL_CNT);
      end
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: a queue-based model predicts retire
// events and pointers; a monitor compares every pulse the DUT raises.
module tb_reorder_buffer;
  logic        clk = 1'b0, rst = 1'b1, rdy;
  logic        issue_valid, issue_pred_taken;
  logic [1:0]  issue_type;
  logic [4:0]  issue_rd;
  logic [31:0] issue_value, issue_pc, issue_target;
  logic [3:0]  rob_tail_id, rob_head_id;
  logic        rob_full;
  logic        alu_ready, lsb_ready;
  logic [3:0]  alu_rob_id, lsb_rob_id, q1_id, q2_id;
  logic [31:0] alu_value, lsb_value, q1_value, q2_value;
  logic        q1_ready, q2_ready;
  logic        commit_reg_valid, commit_store, flush;
  logic [4:0]  commit_rd;
  logic [31:0] commit_value, flush_pc;
  logic [3:0]  commit_rob_id;

  reorder_buffer #(.ROB_BITS(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .issue_valid(issue_valid), .issue_type(issue_type), .issue_rd(issue_rd),
    .issue_value(issue_value), .issue_pc(issue_pc), .issue_target(issue_target),
    .issue_pred_taken(issue_pred_taken),
    .rob_tail_id(rob_tail_id), .rob_head_id(rob_head_id), .rob_full(rob_full),
    .alu_ready(alu_ready), .alu_rob_id(alu_rob_id), .alu_value(alu_value),
    .lsb_ready(lsb_ready), .lsb_rob_id(lsb_rob_id), .lsb_value(lsb_value),
    .q1_id(q1_id), .q2_id(q2_id), .q1_ready(q1_ready), .q2_ready(q2_ready),
    .q1_value(q1_value), .q2_value(q2_value),
    .commit_reg_valid(commit_reg_valid), .commit_rd(commit_rd),
    .commit_value(commit_value), .commit_rob_id(commit_rob_id),
    .commit_store(commit_store), .flush(flush), .flush_pc(flush_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id; logic [1:0] t; logic [4:0] rd; logic [31:0] val;
    bit done; logic [31:0] pc, tgt; bit pred;
  } ent_t;
  typedef struct { int edge_no; int kind; logic [4:0] rd; logic [31:0] val; int id; } exp_t;

  ent_t mq[$];   // in-flight instructions, oldest first
  exp_t sb[$];   // expected retire pulses
  int   m_head, m_tail;
  bit   m_full, m_flush;
  int   edge_n = 0, n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    mq.delete(); m_head = 0; m_tail = 0; m_full = 0; m_flush = 0;
  endfunction

  // Predicts what the upcoming clock edge does, from the architectural rules.
  function automatic void model_step();
    ent_t h, n; exp_t e; bit ret, mis;
    if (!rdy) return;
    if (m_flush) begin m_flush = 0; return; end
    ret = (mq.size() > 0) && mq[0].done;
    if (ret) h = mq[0];
    foreach (mq[i]) if (lsb_ready && mq[i].id == int'(lsb_rob_id)) begin mq[i].val = lsb_value; mq[i].done = 1; end
    foreach (mq[i]) if (alu_ready && mq[i].id == int'(alu_rob_id)) begin mq[i].val = alu_value; mq[i].done = 1; end
    mis = 0;
    if (ret) begin
      void'(mq.pop_front());
      m_head = (m_head + 1) % 16;
      e.edge_no = edge_n + 1; e.rd = h.rd; e.val = h.val; e.id = h.id;
      if (h.t == 2'd0 || h.t == 2'd3) begin e.kind = 0; sb.push_back(e); end
      else if (h.t == 2'd1) begin e.kind = 1; sb.push_back(e); end
      else if (h.val[0] != h.pred) begin
        e.kind = 2; e.val = h.val[0] ? h.tgt : h.pc + 32'd4; sb.push_back(e); mis = 1;
      end
    end
    if (mis) begin model_reset(); m_flush = 1; return; end
    if (issue_valid && !m_full) begin
      n.id = m_tail; n.t = issue_type; n.rd = issue_rd; n.val = issue_value;
      n.done = (issue_type == 2'd3); n.pc = issue_pc; n.tgt = issue_target; n.pred = issue_pred_taken;
      mq.push_back(n);
      m_tail = (m_tail + 1) % 16;
    end
    m_full = (mq.size() == 16);
  endfunction

  // Expected lookup result; returns 0 when the id is not in flight.
  function automatic bit model_lookup(input int id, output bit r, output logic [31:0] v);
    r = 0; v = '0;
    foreach (mq[i]) if (mq[i].id == id) begin
      if (mq[i].done) begin r = 1; v = mq[i].val; end
      else if (alu_ready && int'(alu_rob_id) == id) begin r = 1; v = alu_value; end
      else if (lsb_ready && int'(lsb_rob_id) == id) begin r = 1; v = lsb_value; end
      return 1;
    end
    return 0;
  endfunction

  // Monitor: every pulse raised by an enabled edge must match the scoreboard head.
  always @(posedge clk) begin
    bit en; int n, kind; exp_t e;
    en = rdy && !rst;
    edge_n++;
    #1;
    if (en) begin
      n = int'(commit_reg_valid) + int'(commit_store) + int'(flush);
      kind = commit_reg_valid ? 0 : (commit_store ? 1 : 2);
      if (n > 1) chk("one_pulse", 32'(n), 32'd1);
      if (n >= 1) begin
        if (sb.size() == 0 || sb[0].edge_no != edge_n) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_pulse: got kind %0d at edge %0d, expected none", kind, edge_n);
        end else begin
          e = sb.pop_front();
          chk("pulse_kind", 32'(kind), 32'(e.kind));
          if (e.kind == 0) begin
            chk("commit_rd", 32'(commit_rd), 32'(e.rd));
            chk("commit_value", commit_value, e.val);
            chk("commit_rob_id", 32'(commit_rob_id), 32'(e.id));
          end else if (e.kind == 2) chk("flush_pc", flush_pc, e.val);
        end
      end else if (sb.size() > 0 && sb[0].edge_no == edge_n) begin
        n_chk++; n_fail++;
        $display("FAIL missing_pulse: got none at edge %0d, expected kind %0d", edge_n, sb[0].kind);
        void'(sb.pop_front());
      end
    end
  end

  task automatic idle();
    rdy = 1; issue_valid = 0; issue_type = 0; issue_rd = 0; issue_value = 0;
    issue_pc = 0; issue_target = 0; issue_pred_taken = 0;
    alu_ready = 0; alu_rob_id = 0; alu_value = 0;
    lsb_ready = 0; lsb_rob_id = 0; lsb_value = 0; q1_id = 0; q2_id = 0;
  endtask

  task automatic issue(input logic [1:0] t, input logic [4:0] rd, input logic [31:0] v);
    issue_valid = 1; issue_type = t; issue_rd = rd; issue_value = v;
  endtask

  // Inputs are already driven (at a negedge); check lookups, predict, advance.
  task automatic tick();
    bit r; logic [31:0] v;
    #1;
    if (model_lookup(int'(q1_id), r, v)) begin
      chk("q1_ready", 32'(q1_ready), 32'(r));
      chk("q1_value", q1_value, v);
    end
    if (model_lookup(int'(q2_id), r, v)) begin
      chk("q2_ready", 32'(q2_ready), 32'(r));
      chk("q2_value", q2_value, v);
    end
    model_step();
    @(negedge clk);
    chk("head_id", 32'(rob_head_id), 32'(m_head));
    chk("tail_id", 32'(rob_tail_id), 32'(m_tail));
    chk("rob_full", 32'(rob_full), 32'(m_full));
  endtask

  task automatic do_reset();
    idle(); rst = 1;
    @(negedge clk); @(negedge clk);
    rst = 0;
    model_reset();
    chk("rst_head", 32'(rob_head_id), 32'd0);
    chk("rst_tail", 32'(rob_tail_id), 32'd0);
    chk("rst_full", 32'(rob_full), 32'd0);
    chk("rst_commit_reg", 32'(commit_reg_valid), 32'd0);
    chk("rst_commit_store", 32'(commit_store), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_commit_value", commit_value, 32'd0);
    chk("rst_flush_pc", flush_pc, 32'd0);
  endtask

  function automatic int pick_id();
    if (mq.size() > 0 && $urandom_range(0, 3) != 0) return mq[$urandom_range(0, mq.size() - 1)].id;
    return int'($urandom_range(0, 15));
  endfunction

  initial begin
    int k;
    idle();
    do_reset();

    // Three REG_DONE issues retire on consecutive cycles.
    for (int i = 0; i < 3; i++) begin
      idle(); chk("t1_issue_id", 32'(rob_tail_id), 32'(i));
      issue(2'd3, 5'(i + 1), 32'((i + 1) * 10)); tick();
    end
    idle(); repeat (3) tick();

    // Fill all 16 entries, then free id 0 and reuse it.
    do_reset();
    for (int i = 0; i < 16; i++) begin idle(); issue(2'd0, 5'(i), 32'd0); tick(); end
    chk("t2_full", 32'(rob_full), 32'd1);
    idle(); issue(2'd0, 5'd9, 32'd0); alu_ready = 1; alu_rob_id = 0; alu_value = 32'h1234; tick();
    idle(); tick();
    chk("t2_full_drop", 32'(rob_full), 32'd0);
    chk("t2_wrap_id", 32'(rob_tail_id), 32'd0);
    issue(2'd0, 5'd7, 32'd0); tick();
    idle(); tick();

    // Out-of-order completion, in-order commit.
    do_reset();
    issue(2'd0, 5'd4, 32'd0); tick();
    idle(); issue(2'd0, 5'd5, 32'd0); tick();
    idle(); lsb_ready = 1; lsb_rob_id = 1; lsb_value = 32'hB; tick();
    idle(); repeat (2) tick();
    alu_ready = 1; alu_rob_id = 0; alu_value = 32'hA; tick();
    idle(); repeat (3) tick();

    // Mispredicted branch: flush to the taken target, younger work ignored.
    do_reset();
    issue(2'd2, 5'd0, 32'd0); issue_pc = 32'h100; issue_target = 32'h200; issue_pred_taken = 0; tick();
    idle(); issue(2'd0, 5'd6, 32'd0); alu_ready = 1; alu_rob_id = 0; alu_value = 32'd1; tick();
    idle(); tick();
    chk("t4_flush", 32'(flush), 32'd1);
    chk("t4_flush_pc", flush_pc, 32'h200);
    issue(2'd3, 5'd8, 32'h99); alu_ready = 1; alu_rob_id = 1; alu_value = 32'h77; tick();
    idle(); repeat (2) tick();

    // Same-cycle bypass on lookup.
    do_reset();
    for (int i = 0; i < 3; i++) begin idle(); issue(2'd0, 5'(i), 32'd0); tick(); end
    idle(); q1_id = 2; alu_ready = 1; alu_rob_id = 2; alu_value = 32'h55;
    #1;
    chk("t5_q1_ready", 32'(q1_ready), 32'd1);
    chk("t5_q1_value", q1_value, 32'h55);
    tick();
    idle(); tick();

    // rdy low freezes a ready head.
    do_reset();
    issue(2'd3, 5'd3, 32'hCAFE); tick();
    idle(); rdy = 0; repeat (3) tick();
    rdy = 1; tick();
    idle(); tick();

    // Randomized traffic; second phase starves results so the buffer fills.
    do_reset();
    for (int ph = 0; ph < 2; ph++) begin
      for (int c = 0; c < 1500; c++) begin
        rdy = ($urandom_range(0, 9) != 0);
        issue_valid = 1'($urandom_range(0, 1));
        k = int'($urandom_range(0, 9));
        issue_type = (k < 5) ? 2'd0 : (k < 7) ? 2'd1 : (k < 8) ? 2'd2 : 2'd3;
        issue_rd = 5'($urandom); issue_value = $urandom;
        issue_pc = $urandom & 32'hFFFF_FFFC; issue_target = $urandom & 32'hFFFF_FFFC;
        issue_pred_taken = 1'($urandom_range(0, 1));
        alu_ready = ($urandom_range(0, 99) < (ph == 0 ? 45 : 12));
        alu_rob_id = 4'(pick_id()); alu_value = $urandom;
        lsb_ready = ($urandom_range(0, 99) < (ph == 0 ? 30 : 8));
        lsb_rob_id = ($urandom_range(0, 4) == 0) ? alu_rob_id : 4'(pick_id());
        lsb_value = $urandom;
        q1_id = 4'(pick_id()); q2_id = 4'(pick_id());
        tick();
        if (c == 700) do_reset();
      end
    end
    idle(); repeat (2) tick();

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
